// File: rtl/band_pkg.sv
// Shared types and constants for the band capture and playback blocks.
package band_pkg;

  // One audio sample as it leaves the input/filter chain.
  typedef logic signed [15:0] sample_t;

  // Record controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } rec_state_t;

  // Audio sample rate and the fabric clock it is strobed into.
  localparam int SAMPLE_RATE_HZ = 44000;
  localparam int CLK_HZ         = 4400000;
  localparam int CLK_PER_SAMPLE = CLK_HZ / SAMPLE_RATE_HZ;

  // Magnitude of a signed sample. -32768 has no positive twin in 16 bits,
  // so it is clamped to 32767 rather than wrapping back to itself.
  function automatic logic [15:0] sat_abs(input sample_t s);
    logic [15:0] raw;
    raw = s;
    if (raw == 16'h8000) begin
      return 16'h7fff;
    end
    if (raw[15]) begin
      return ~raw + 16'd1;
    end
    return raw;
  endfunction

endpackage

// File: rtl/band_trigger.sv
// Level trigger: a strobed sample fires when its saturated magnitude reaches
// THRESH. Purely combinational so the owner decides when to act on it.
module band_trigger
  import band_pkg::*;
#(
  parameter int THRESH = 0
) (
  input  logic [15:0] sample,
  input  logic        valid,
  output logic        hit
);

  // THRESH is compared one bit wider than the magnitude so a threshold of
  // 32768 or more simply never fires instead of aliasing.
  localparam logic [16:0] THRESH_W = 17'(THRESH);

  logic [15:0] magnitude;

  // Magnitude and compare; THRESH = 0 fires on every strobed sample.
  always_comb begin
    magnitude = sat_abs(sample_t'(sample));
    hit       = valid && ({1'b0, magnitude} >= THRESH_W);
  end

endmodule

// File: rtl/band_record.sv
// Capture side of a band: writes the 44 kHz sample stream into the band
// BRAM write port with start/stop control, an optional level trigger and a
// ring (loop) mode. sample_count tells playback how far it may read.
//
// Write-port contract: there is no back-pressure. A sample is accepted on the
// clock edge where valid_in is high and the controller is either triggering
// in ARMED or running in RECORD. The matching write appears one cycle later
// as a single-cycle bram_we pulse with bram_addr/bram_wdata; both hold their
// last value while bram_we is low.
module band_record
  import band_pkg::*;
#(
  parameter int MEM_DEPTH  = 4036,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int THRESH     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [15:0]           data_in,
  input  logic                  valid_in,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [15:0]           bram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_WIDTH:0]   sample_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);

  // Controller state; kept as a named signal so it can be probed directly.
  rec_state_t state;
  rec_state_t state_next;

  logic [ADDR_WIDTH-1:0] ptr;        // address the next accepted sample goes to
  logic                  trig;       // ARMED trigger condition for this cycle
  logic                  at_end;     // next write lands on the last word
  logic                  wr_accept;  // a sample is accepted this cycle
  logic                  clear_take; // a new take begins this cycle

  band_trigger #(
    .THRESH(THRESH)
  ) u_trigger (
    .sample(data_in),
    .valid (valid_in),
    .hit   (trig)
  );

  assign at_end = (ptr == LAST_ADDR);

  // State register; reset aborts any take on the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the accept/clear strobes for the datapath.
  always_comb begin
    state_next = state;
    wr_accept  = 1'b0;
    clear_take = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
          clear_take = 1'b1;
        end
      end
      ARMED: begin
        // stop wins over a trigger in the same cycle: nothing is written.
        if (stop) begin
          state_next = DONE;
        end else if (trig) begin
          wr_accept  = 1'b1;
          state_next = (at_end && !loop_en) ? DONE : RECORD;
        end
      end
      RECORD: begin
        if (valid_in) begin
          wr_accept = 1'b1;
          if (stop || (at_end && !loop_en)) begin
            state_next = DONE;
          end
        end else if (stop) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = ARMED;
          clear_take = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write port, pointer, take length and wrap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
      ptr          <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
    end else begin
      bram_we <= wr_accept;
      if (clear_take) begin
        ptr          <= '0;
        sample_count <= '0;
        wrapped      <= 1'b0;
      end
      if (wr_accept) begin
        bram_addr  <= ptr;
        bram_wdata <= data_in;
        ptr        <= at_end ? '0 : ptr + ADDR_ONE;
        if (sample_count != FULL_COUNT) begin
          sample_count <= sample_count + COUNT_ONE;
        end
        // Pointer back at 0 with words already written means the ring has
        // come around: the previous write was to the last address.
        if ((ptr == '0) && (sample_count != '0)) begin
          wrapped <= 1'b1;
        end
      end
    end
  end

  // Status is a straight decode of the state register.
  always_comb begin
    busy = (state == ARMED) || (state == RECORD);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_band_record.sv
// Bench for band_record: two instances (no threshold / threshold 100) share
// one input stream and are compared every cycle against a take-level model.
module tb_band_record;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        valid_in;
  logic [15:0] data_in;

  logic        bram_we      [2];
  logic [2:0]  bram_addr    [2];
  logic [15:0] bram_wdata   [2];
  logic        busy         [2];
  logic        done         [2];
  logic        wrapped      [2];
  logic [3:0]  sample_count [2];

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
  // Takes are tracked by the unsaturated number of words written (m_nwr);
  // address, count and wrap all follow from it arithmetically.
  int          thr   [2] = '{0, 100};
  int          m_ph  [2];
  int          m_nwr [2];
  logic        m_we  [2];
  int          m_addr[2];
  logic [15:0] m_wd  [2];
  logic        m_wrap[2];

  logic [18:0] exp_q[$];

  band_record #(.MEM_DEPTH(DEPTH), .THRESH(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .data_in(data_in), .valid_in(valid_in),
    .bram_we(bram_we[0]), .bram_addr(bram_addr[0]), .bram_wdata(bram_wdata[0]),
    .busy(busy[0]), .done(done[0]), .wrapped(wrapped[0]),
    .sample_count(sample_count[0])
  );

  band_record #(.MEM_DEPTH(DEPTH), .THRESH(100)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .data_in(data_in), .valid_in(valid_in),
    .bram_we(bram_we[1]), .bram_addr(bram_addr[1]), .bram_wdata(bram_wdata[1]),
    .busy(busy[1]), .done(done[1]), .wrapped(wrapped[1]),
    .sample_count(sample_count[1])
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mag(input logic [15:0] x);
    int s;
    s = $signed(x);
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  task automatic model_write(input int k);
    m_we[k]   = 1'b1;
    m_addr[k] = m_nwr[k] % DEPTH;
    m_wd[k]   = data_in;
    if (m_nwr[k] >= DEPTH) m_wrap[k] = 1'b1;
    m_nwr[k]++;
  endtask

  task automatic model_step(input int k);
    logic fire;
    fire = valid_in && (mag(data_in) >= thr[k]);
    if (rst) begin
      m_ph[k] = 0; m_nwr[k] = 0; m_we[k] = 1'b0;
      m_addr[k] = 0; m_wd[k] = '0; m_wrap[k] = 1'b0;
      return;
    end
    m_we[k] = 1'b0;
    case (m_ph[k])
      0, 3: begin
        if (start) begin
          m_ph[k] = 1; m_nwr[k] = 0; m_wrap[k] = 1'b0;
        end
      end
      1: begin
        if (stop) m_ph[k] = 3;
        else if (fire) begin
          model_write(k);
          m_ph[k] = (m_addr[k] == DEPTH - 1 && !loop_en) ? 3 : 2;
        end
      end
      default: begin
        if (valid_in) begin
          model_write(k);
          if (stop || (m_addr[k] == DEPTH - 1 && !loop_en)) m_ph[k] = 3;
        end else if (stop) m_ph[k] = 3;
      end
    endcase
  endtask

  task automatic compare_all();
    int cnt;
    for (int k = 0; k < 2; k++) begin
      cnt = (m_nwr[k] > DEPTH) ? DEPTH : m_nwr[k];
      check($sformatf("d%0d_we", k),    32'(bram_we[k]),      32'(m_we[k]));
      check($sformatf("d%0d_addr", k),  32'(bram_addr[k]),    32'(m_addr[k]));
      check($sformatf("d%0d_wdata", k), 32'(bram_wdata[k]),   32'(m_wd[k]));
      check($sformatf("d%0d_busy", k),  32'(busy[k]),         32'(m_ph[k] == 1 || m_ph[k] == 2));
      check($sformatf("d%0d_done", k),  32'(done[k]),         32'(m_ph[k] == 3));
      check($sformatf("d%0d_wrap", k),  32'(wrapped[k]),      32'(m_wrap[k]));
      check($sformatf("d%0d_count", k), 32'(sample_count[k]), 32'(cnt));
    end
    // scoreboard on the unthresholded instance's write stream
    if (bram_we[0] === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 32'd1, 32'd0);
      else check("sb_write", 32'({bram_addr[0], bram_wdata[0]}), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    if (m_we[0]) exp_q.push_back({3'(m_addr[0]), m_wd[0]});
    #1;
    compare_all();
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic sample(input logic [15:0] d);
    data_in = d; valid_in = 1'b1; tick();
    valid_in = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    valid_in = 1'b0; data_in = '0;
    tick(); tick();
    check("reset_we", 32'(bram_we[0]), 32'd0);
    check("reset_count", 32'(sample_count[0]), 32'd0);
    check("reset_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;

    // fill without loop: only the first 8 of 10 samples land
    pulse_start();
    for (int i = 1; i <= 10; i++) sample(16'(i));
    check("fill_done", 32'(done[0]), 32'd1);
    check("fill_count", 32'(sample_count[0]), 32'd8);
    check("fill_wrapped", 32'(wrapped[0]), 32'd0);
    check("fill_last_data", 32'(bram_wdata[0]), 32'd8);
    check("thr_still_armed", 32'(busy[1]), 32'd1);
    pulse_stop();

    // threshold 100: -150 is the first word of the take
    pulse_start();
    sample(16'd5);
    sample(-16'sd50);
    sample(-16'sd150);
    check("thr_first_addr", 32'(bram_addr[1]), 32'd0);
    check("thr_first_data", 32'(bram_wdata[1]), 32'h0000ff6a);
    sample(16'd20);
    check("thr_second_addr", 32'(bram_addr[1]), 32'd1);
    check("thr_count", 32'(sample_count[1]), 32'd2);
    pulse_stop();
    pulse_start();
    sample(16'h8000);
    check("thr_min_trig", 32'(bram_wdata[1]), 32'h00008000);
    check("thr_min_count", 32'(sample_count[1]), 32'd1);
    pulse_stop();

    // loop mode: 11 samples wrap onto 0,1,2
    loop_en = 1'b1;
    pulse_start();
    for (int i = 1; i <= 11; i++) sample(16'(i));
    check("loop_wrapped", 32'(wrapped[0]), 32'd1);
    check("loop_count", 32'(sample_count[0]), 32'd8);
    check("loop_busy", 32'(busy[0]), 32'd1);
    check("loop_addr", 32'(bram_addr[0]), 32'd2);

    // stop with valid in RECORD: sample still written, done already high
    stop = 1'b1; valid_in = 1'b1; data_in = 16'd77; tick();
    stop = 1'b0; valid_in = 1'b0;
    check("stopv_we", 32'(bram_we[0]), 32'd1);
    check("stopv_data", 32'(bram_wdata[0]), 32'd77);
    check("stopv_done", 32'(done[0]), 32'd1);
    loop_en = 1'b0;

    // new take from DONE clears count and wrap
    pulse_start();
    check("restart_wrap", 32'(wrapped[0]), 32'd0);
    check("restart_count", 32'(sample_count[0]), 32'd0);
    check("restart_busy", 32'(busy[0]), 32'd1);

    // stop in ARMED beats a triggering sample
    stop = 1'b1; valid_in = 1'b1; data_in = 16'd500; tick();
    stop = 1'b0; valid_in = 1'b0;
    check("armstop_we0", 32'(bram_we[0]), 32'd0);
    check("armstop_we1", 32'(bram_we[1]), 32'd0);
    check("armstop_done", 32'(done[0]), 32'd1);

    // reset mid-take, then record again from address 0
    pulse_start();
    sample(16'd10); sample(16'd200); sample(16'd300);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_we", 32'(bram_we[0]), 32'd0);
    check("midrst_addr", 32'(bram_addr[0]), 32'd0);
    check("midrst_count", 32'(sample_count[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    pulse_start();
    sample(16'd150);
    check("rerec_addr", 32'(bram_addr[0]), 32'd0);
    check("rerec_data", 32'(bram_wdata[1]), 32'd150);

    // start in RECORD is ignored
    pulse_start();
    sample(16'd160);
    check("ignstart_addr", 32'(bram_addr[0]), 32'd1);
    check("ignstart_count", 32'(sample_count[0]), 32'd2);
    pulse_stop();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      valid_in = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       data_in = 16'h8000;
        1:       data_in = 16'(0 - $urandom_range(0, 200));
        2:       data_in = 16'($urandom_range(0, 200));
        default: data_in = 16'($urandom);
      endcase
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; valid_in = 1'b0;
    tick();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
